shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 112 +++++++++++
 tb/tb_shift_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA sequencer: shifts a captured operand by at most
// STEP bit positions per clock, with a start/busy/done handshake.
module shift_sequencer #(
    parameter int STEP = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [4:0]  shamt_i,
    output logic [31:0] result_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b11;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [4:0] STEP_AMT = 5'(STEP);

    state_t      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rem_q, rem_d;
    logic [1:0]  op_q, op_d;
    logic        sign_q, sign_d;

    logic [4:0]  step_k;
    logic [31:0] fill_mask;
    logic [31:0] shifted;

    // Never step past the remaining count, so the last step is exact.
    assign step_k    = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    assign fill_mask = ~(32'hFFFF_FFFF >> step_k);

    always_comb begin
        shifted = result_q >> step_k;
        case (op_q)
            OP_SLL:  shifted = result_q << step_k;
            OP_SRA:  shifted = (result_q >> step_k) | (sign_q ? fill_mask : 32'h0);
            default: shifted = result_q >> step_k;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rem_d    = rem_q;
        op_d     = op_q;
        sign_d   = sign_q;
        case (state_q)
            IDLE, DONE: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    op_d     = op_i;
                    sign_d   = a_i[31];
                    result_d = a_i;
                    if (shamt_i != 5'd0 && op_i != OP_PASS) begin
                        rem_d   = shamt_i;
                        state_d = SHIFT;
                    end else begin
                        rem_d   = 5'd0;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (flush_i) begin
                    // Aborted op: result keeps its partial value, no Done pulse.
                    rem_d   = 5'd0;
                    state_d = IDLE;
                end else begin
                    result_d = shifted;
                    rem_d    = rem_q - step_k;
                    state_d  = (rem_q == step_k) ? DONE : SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= 32'h0;
            rem_q    <= 5'd0;
            op_q     <= 2'b00;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
        end
    end

    assign result_o = result_q;
    assign busy_o   = (state_q == SHIFT);
    assign done_o   = (state_q == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed table, handshake corner
// sequences and randomized ops against an arithmetic reference model.
module tb_shift_sequencer;

    localparam int STEP = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        flush_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [4:0]  shamt_i;
    logic [31:0] result_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.STEP(STEP)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .flush_i (flush_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .shamt_i (shamt_i),
        .result_o(result_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  sh;
        int          poke;
        logic [31:0] exp_res;
        int          exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [4:0] sh);
        case (op)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b11:   return $unsigned($signed(a) >>> sh);
            default: return a;
        endcase
    endfunction

    function automatic int ref_shift_cycles(input logic [1:0] op, input logic [4:0] sh);
        if (op == 2'b10 || sh == 5'd0) return 0;
        return (int'(sh) + STEP - 1) / STEP;
    endfunction

    // Issue one op and watch it to completion; poke>0 re-pulses Start with junk
    // operands at that cycle to show it is ignored while busy.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                         input int poke, output int nbusy, output int done_cyc,
                         output logic [31:0] res);
        @(negedge clk_i);
        op_i = op; a_i = a; shamt_i = sh; start_i = 1'b1;
        nbusy = 0; done_cyc = -1; res = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (busy_o) nbusy++;
            if (done_o) begin
                done_cyc = c;
                res = result_o;
            end
            start_i = (c == poke);
            a_i     = $urandom;
            shamt_i = 5'($urandom);
            op_i    = 2'($urandom);
            if (done_cyc >= 0) break;
        end
        start_i = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [4:0] sh, input int poke,
                            input logic [31:0] exp_res, input int exp_busy);
        int nb, dc;
        logic [31:0] res;
        do_op(op, a, sh, poke, nb, dc, res);
        $display("%s op=%b a=%h sh=%0d -> res=%h busy=%0d done@%0d", name, op, a, sh, res, nb, dc);
        chk({name, "_result"}, res, exp_res);
        chk({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        chk({name, "_done_cycle"}, 32'(dc), 32'(exp_busy + 1));
        @(negedge clk_i);
        chk({name, "_done_pulse_width"}, {31'h0, done_o}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen_done;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [4:0]  rsh;
        int          lat, poke;

        vecs[0] = '{2'b00, 32'h8000_0001, 5'd4,  0, 32'h0000_0010, 1};
        vecs[1] = '{2'b11, 32'h8000_0000, 5'd31, 0, 32'hFFFF_FFFF, 8};
        vecs[2] = '{2'b01, 32'h8000_0000, 5'd31, 0, 32'h0000_0001, 8};
        vecs[3] = '{2'b00, 32'h1234_5678, 5'd0,  0, 32'h1234_5678, 0};
        vecs[4] = '{2'b10, 32'h1234_5678, 5'd5,  0, 32'h1234_5678, 0};
        vecs[5] = '{2'b11, 32'h7FFF_FFF0, 5'd4,  0, 32'h07FF_FFFF, 1};
        vecs[6] = '{2'b00, 32'h0000_000F, 5'd1,  0, 32'h0000_001E, 1};
        vecs[7] = '{2'b11, 32'hF000_0000, 5'd16, 2, 32'hFFFF_F000, 4};
        vecs[8] = '{2'b01, 32'hF000_0000, 5'd17, 0, 32'h0000_7800, 5};
        vecs[9] = '{2'b00, 32'h0000_0001, 5'd20, 2, 32'h0010_0000, 5};

        rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        op_i = 2'b00; a_i = 32'h0; shamt_i = 5'd0;
        repeat (2) @(negedge clk_i);
        chk("reset_result", result_o, 32'h0);
        chk("reset_busy", {31'h0, busy_o}, 32'h0);
        chk("reset_done", {31'h0, done_o}, 32'h0);
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++)
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].sh,
                     vecs[i].poke, vecs[i].exp_res, vecs[i].exp_busy);

        // Back-to-back: Start held through the DONE cycle launches a second op.
        @(negedge clk_i);
        op_i = 2'b00; a_i = 32'h1; shamt_i = 5'd4; start_i = 1'b1;
        @(negedge clk_i);
        chk("b2b_busy1", {31'h0, busy_o}, 32'h1);
        a_i = 32'hF; shamt_i = 5'd1;
        @(negedge clk_i);
        chk("b2b_done1", {31'h0, done_o}, 32'h1);
        chk("b2b_result1", result_o, 32'h10);
        @(negedge clk_i);
        chk("b2b_busy2", {31'h0, busy_o}, 32'h1);
        start_i = 1'b0;
        @(negedge clk_i);
        chk("b2b_done2", {31'h0, done_o}, 32'h1);
        chk("b2b_result2", result_o, 32'h1E);
        $display("b2b second result=%h", result_o);
        @(negedge clk_i);
        chk("b2b_idle", {31'h0, done_o}, 32'h0);

        // Flush during the third SHIFT cycle of a Shamt=20 op.
        @(negedge clk_i);
        op_i = 2'b00; a_i = 32'h1; shamt_i = 5'd20; start_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            chk($sformatf("flush_busy_c%0d", c), {31'h0, busy_o}, 32'h1);
            if (c == 3) flush_i = 1'b1;
        end
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush_busy_after", {31'h0, busy_o}, 32'h0);
        chk("flush_done_after", {31'h0, done_o}, 32'h0);
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            if (done_o || busy_o) seen_done = 1'b1;
        end
        chk("flush_no_done", {31'h0, seen_done}, 32'h0);
        $display("flush aborted op, no done pulse seen=%b", seen_done);

        // Flush and Start together in IDLE: stays idle.
        flush_i = 1'b1; start_i = 1'b1; op_i = 2'b00; a_i = 32'h5; shamt_i = 5'd2;
        @(negedge clk_i);
        chk("flush_start_busy", {31'h0, busy_o}, 32'h0);
        chk("flush_start_done", {31'h0, done_o}, 32'h0);
        flush_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        chk("flush_start_idle", {31'h0, busy_o | done_o}, 32'h0);

        // Asynchronous reset between edges mid-SHIFT.
        @(negedge clk_i);
        op_i = 2'b11; a_i = 32'h8000_0000; shamt_i = 5'd31; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        chk("arst_pre_busy", {31'h0, busy_o}, 32'h1);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_result", result_o, 32'h0);
        chk("arst_busy", {31'h0, busy_o}, 32'h0);
        chk("arst_done", {31'h0, done_o}, 32'h0);
        $display("async reset mid-shift result=%h busy=%b done=%b", result_o, busy_o, done_o);
        #1 rst_i = 1'b0;
        check_op("post_reset", 2'b01, 32'hF000_0000, 5'd8, 0, 32'h00F0_0000, 2);

        // Random ops against the reference model.
        for (int i = 0; i < 200; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rsh = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            lat = ref_shift_cycles(rop, rsh);
            poke = (lat > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, lat)) : 0;
            check_op($sformatf("rnd%0d", i), rop, ra, rsh, poke, ref_result(rop, ra, rsh), lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
